// File: rtl/bmw_sched_pkg.sv
// Shared types and sizing helper for the BMW PIFO tree op scheduler.
package bmw_sched_pkg;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP
  } op_e;

  typedef enum logic {
    S_ISSUE,
    S_GAP
  } state_e;

  // Width needed to hold an occupancy value in the range 0..cap.
  function automatic int unsigned cnt_w(input int unsigned cap);
    return (cap < 1) ? 1 : $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/bmw_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last accepted index.
module bmw_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         i_clk,
  input  logic         i_arst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_accept,
  output logic [N-1:0] o_gnt
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  always_comb begin
    logic        found;
    int unsigned idx;
    o_gnt = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      if (!found && i_req[IW'(idx)]) begin
        found            = 1'b1;
        o_gnt[IW'(idx)]  = 1'b1;
        ptr_d            = IW'(idx);
      end
    end
  end

  // Pointer starts at N-1 so requester 0 is searched first after reset.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ptr_q <= IW'(N - 1);
    end else if (i_accept) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bmw_op_scheduler.sv
// Push/pop front-end for the SRAM-backed BMW PIFO tree: arbitration, issue spacing, occupancy, responses.
// Optional statistics counters are enabled by defining BMW_SCHED_STATS_EN.
module bmw_op_scheduler
  import bmw_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 16,
  parameter int unsigned CAP     = 340,
  parameter int unsigned OP_GAP  = 2,
  parameter int unsigned POP_LAT = 1
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic [NREQ-1:0]        i_push_valid,
  input  logic [NREQ*DW-1:0]     i_push_data,
  output logic [NREQ-1:0]        o_push_ready,
  input  logic                   i_pop_valid,
  output logic                   o_pop_ready,
  output logic                   o_rsp_valid,
  output logic [DW-1:0]          o_rsp_data,
  output logic                   o_tree_push,
  output logic [DW-1:0]          o_tree_push_data,
  output logic                   o_tree_pop,
  input  logic [DW-1:0]          i_tree_pop_data,
  output logic [cnt_w(CAP)-1:0]  o_count,
  output logic                   o_full,
`ifdef BMW_SCHED_STATS_EN
  output logic [31:0]            o_stat_push,
  output logic [31:0]            o_stat_pop,
  output logic [31:0]            o_stat_stall,
`endif
  output logic                   o_empty
);

  localparam int unsigned CW = cnt_w(CAP);
  localparam int unsigned GW = (OP_GAP > 1) ? $clog2(OP_GAP) : 1;

  state_e          state_q;
  op_e             last_op_q;
  logic [GW-1:0]   gap_q;
  logic [CW-1:0]   count_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_data_q;

  logic            full_c;
  logic            empty_c;
  logic            push_ok_c;
  logic            pop_ok_c;
  op_e             op_c;
  logic [NREQ-1:0] gnt_c;
  logic [DW-1:0]   push_data_c;
  logic            capture_c;

  assign full_c  = (count_q == CW'(CAP));
  assign empty_c = (count_q == '0);

  // Issue decision: only in S_ISSUE; on a push/pop tie the op opposite to the last one wins.
  always_comb begin
    push_ok_c = (state_q == S_ISSUE) && (|i_push_valid) && !full_c;
    pop_ok_c  = (state_q == S_ISSUE) && i_pop_valid && !empty_c;
    op_c      = OP_NONE;
    if (push_ok_c && pop_ok_c) begin
      op_c = (last_op_q == OP_PUSH) ? OP_POP : OP_PUSH;
    end else if (push_ok_c) begin
      op_c = OP_PUSH;
    end else if (pop_ok_c) begin
      op_c = OP_POP;
    end
  end

  bmw_rr_arbiter #(
    .N (NREQ)
  ) u_rr_arbiter (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_req    (i_push_valid),
    .i_accept (op_c == OP_PUSH),
    .o_gnt    (gnt_c)
  );

  // One-hot select of the granted requester's data.
  always_comb begin
    push_data_c = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt_c[k]) begin
        push_data_c = push_data_c | i_push_data[k*DW +: DW];
      end
    end
  end

  assign o_push_ready     = (op_c == OP_PUSH) ? gnt_c : '0;
  assign o_tree_push      = (op_c == OP_PUSH);
  assign o_tree_push_data = (op_c == OP_PUSH) ? push_data_c : '0;
  assign o_pop_ready      = (op_c == OP_POP);
  assign o_tree_pop       = (op_c == OP_POP);

  // Issue-spacing FSM and tie-break history.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= S_ISSUE;
      last_op_q <= OP_PUSH;
      gap_q     <= '0;
    end else begin
      case (state_q)
        S_ISSUE: begin
          if (op_c != OP_NONE) begin
            last_op_q <= op_c;
            if (OP_GAP > 1) begin
              state_q <= S_GAP;
              gap_q   <= GW'(OP_GAP - 1);
            end
          end
        end
        S_GAP: begin
          gap_q <= gap_q - GW'(1);
          if (gap_q <= GW'(1)) begin
            state_q <= S_ISSUE;
          end
        end
        default: begin
          state_q <= S_ISSUE;
        end
      endcase
    end
  end

  // Occupancy: push and pop never issue in the same cycle.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      count_q <= '0;
    end else if (op_c == OP_PUSH) begin
      count_q <= count_q + CW'(1);
    end else if (op_c == OP_POP) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign o_count = count_q;
  assign o_full  = full_c;
  assign o_empty = empty_c;

  // Pop-latency tracker: capture_c marks the cycle the tree's pop data is valid.
  if (POP_LAT == 0) begin : g_lat0
    assign capture_c = (op_c == OP_POP);
  end else begin : g_latn
    logic [POP_LAT-1:0] pipe_q;
    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= (pipe_q << 1) | POP_LAT'(op_c == OP_POP);
      end
    end
    assign capture_c = pipe_q[POP_LAT-1];
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= capture_c;
      if (capture_c) begin
        rsp_data_q <= i_tree_pop_data;
      end
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;

`ifdef BMW_SCHED_STATS_EN
  logic [31:0] stat_push_q;
  logic [31:0] stat_pop_q;
  logic [31:0] stat_stall_q;
  logic        stall_c;

  // A stall is an idle issue slot while some request is held back by full/empty.
  assign stall_c = (state_q == S_ISSUE) && (op_c == OP_NONE) &&
                   (((|i_push_valid) && full_c) || (i_pop_valid && empty_c));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      stat_push_q  <= '0;
      stat_pop_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      if (op_c == OP_PUSH) stat_push_q  <= stat_push_q + 32'd1;
      if (op_c == OP_POP)  stat_pop_q   <= stat_pop_q + 32'd1;
      if (stall_c)         stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign o_stat_push  = stat_push_q;
  assign o_stat_pop   = stat_pop_q;
  assign o_stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_bmw_op_scheduler.sv
// Directed bench for bmw_op_scheduler with a sorted-queue tree model and a response scoreboard.
module tb_bmw_op_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 16;
  localparam int unsigned CAP  = 340;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      push_valid = '0;
  logic [NREQ*DW-1:0]   push_data = '0;
  logic [NREQ-1:0]      push_ready;
  logic                 pop_valid = 1'b0;
  logic                 pop_ready;
  logic                 rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 tree_push;
  logic [DW-1:0]        tree_push_data;
  logic                 tree_pop;
  logic [DW-1:0]        tree_pop_data = 16'hDEAD;
  logic [8:0]           count;
  logic                 full;
  logic                 empty;
`ifdef BMW_SCHED_STATS_EN
  logic [31:0]          stat_push;
  logic [31:0]          stat_pop;
  logic [31:0]          stat_stall;
`endif

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int unsigned tree_q[$];
  exp_t        exp_q[$];
  logic [DW-1:0] got_q[$];
  bit          pend = 1'b0;
  logic [DW-1:0] pend_val = '0;

  bmw_op_scheduler u_dut (
    .i_clk            (clk),
    .i_arst_n         (rst_n),
    .i_push_valid     (push_valid),
    .i_push_data      (push_data),
    .o_push_ready     (push_ready),
    .i_pop_valid      (pop_valid),
    .o_pop_ready      (pop_ready),
    .o_rsp_valid      (rsp_valid),
    .o_rsp_data       (rsp_data),
    .o_tree_push      (tree_push),
    .o_tree_push_data (tree_push_data),
    .o_tree_pop       (tree_pop),
    .i_tree_pop_data  (tree_pop_data),
    .o_count          (count),
    .o_full           (full),
`ifdef BMW_SCHED_STATS_EN
    .o_stat_push      (stat_push),
    .o_stat_pop       (stat_pop),
    .o_stat_stall     (stat_stall),
`endif
    .o_empty          (empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void tree_insert(input int unsigned v);
    int pos;
    pos = tree_q.size();
    for (int i = tree_q.size() - 1; i >= 0; i--) begin
      if (tree_q[i] > v) pos = i;
    end
    tree_q.insert(pos, v);
  endfunction

  // Tree model: min-first PIFO with POP_LAT=1; also checks occupancy and issue legality.
  always @(negedge clk) begin
    if (!rst_n) begin
      tree_q.delete();
      exp_q.delete();
      pend = 1'b0;
    end else begin
      check("count", count, tree_q.size());
      check("empty", empty, tree_q.size() == 0);
      check("full", full, tree_q.size() == CAP);
      if (tree_push || tree_pop) check("one_op", tree_push & tree_pop, 0);
      if (tree_push) begin
        check("push_not_full", tree_q.size() < CAP, 1);
        tree_insert(tree_push_data);
      end
      if (tree_pop) begin
        check("pop_not_empty", tree_q.size() > 0, 1);
        if (tree_q.size() > 0) begin
          exp_t e;
          pend_val = DW'(tree_q.pop_front());
          pend     = 1'b1;
          e.data   = pend_val;
          e.cyc    = cyc + 2;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Pop data is valid only during the cycle after the pop issues.
  always @(posedge clk) begin
    #1;
    if (pend) begin
      tree_pop_data = pend_val;
      pend = 1'b0;
    end else begin
      tree_pop_data = 16'hDEAD;
    end
  end

  // Response scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_cycle", cyc, e.cyc);
      end
      got_q.push_back(rsp_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_op(input int budget, output bit gp, output bit gq, output int at);
    gp = 1'b0;
    gq = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tree_push || tree_pop) begin
        gp = tree_push;
        gq = tree_pop;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    tick();
    rst_n      = 1'b0;
    push_valid = '0;
    pop_valid  = 1'b0;
    @(negedge clk);
    check("rst_push_ready", push_ready, 0);
    check("rst_pop_ready", pop_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_tree_push", tree_push, 0);
    check("rst_tree_pop", tree_pop, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_one(input int k, input logic [DW-1:0] d, input string tag);
    bit gp, gq;
    int at;
    push_data[k*DW +: DW] = d;
    push_valid[k] = 1'b1;
    wait_op(4, gp, gq, at);
    check({tag, "_push"}, gp, 1);
    check({tag, "_ready"}, push_ready, 4'b0001 << k);
    check({tag, "_data"}, tree_push_data, d);
    tick();
    push_valid[k] = 1'b0;
  endtask

  task automatic pop_one(input string tag);
    bit gp, gq;
    int at;
    pop_valid = 1'b1;
    wait_op(4, gp, gq, at);
    check({tag, "_pop"}, gq, 1);
    check({tag, "_pop_ready"}, pop_ready, 1);
    tick();
    pop_valid = 1'b0;
  endtask

  initial begin
    bit gp, gq;
    int at, prev;

    #1 rst_n = 1'b0;
    do_reset();

    // 1: single push, no re-issue during the gap
    push_data[DW-1:0] = 16'h0010;
    push_valid = 4'b0001;
    @(negedge clk);
    check("t1_tree_push", tree_push, 1);
    check("t1_ready", push_ready, 4'b0001);
    check("t1_data", tree_push_data, 16'h0010);
    tick();
    @(negedge clk);
    check("t1_gap_push", tree_push, 0);
    check("t1_gap_ready", push_ready, 0);
    check("t1_count", count, 1);
    check("t1_empty", empty, 0);
    tick();
    push_valid = '0;
    @(negedge clk);
    check("t1_idle_push", tree_push, 0);

    // 2: round-robin with all requesters valid
    do_reset();
    push_data  = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    push_valid = 4'hF;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_op(4, gp, gq, at);
      check("t2_push", gp, 1);
      check("t2_grant", push_ready, 4'b0001 << (n % 4));
      check("t2_data", tree_push_data, 16'h00A0 + 16'(n % 4));
      if (n > 0) check("t2_spacing", at - prev, 2);
      prev = at;
    end
    tick();
    push_valid = '0;
    tick();
    check("t2_count", count, 5);

    // 3: pops return in priority order
    do_reset();
    got_q.delete();
    push_one(0, 16'h0030, "t3a");
    push_one(1, 16'h0010, "t3b");
    push_one(2, 16'h0020, "t3c");
    pop_one("t3p0");
    pop_one("t3p1");
    pop_one("t3p2");
    repeat (3) tick();
    check("t3_nrsp", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t3_rsp0", got_q[0], 16'h0010);
      check("t3_rsp1", got_q[1], 16'h0020);
      check("t3_rsp2", got_q[2], 16'h0030);
    end
    check("t3_count", count, 0);

    // 4: pop waits on empty until a push lands
    do_reset();
    got_q.delete();
    pop_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t4_blocked_ready", pop_ready, 0);
      check("t4_blocked_pop", tree_pop, 0);
    end
    tick();
    push_data[3*DW +: DW] = 16'h0005;
    push_valid[3] = 1'b1;
    wait_op(4, gp, gq, at);
    check("t4_push_first", gp, 1);
    check("t4_push_ready", push_ready, 4'b1000);
    prev = at;
    tick();
    push_valid[3] = 1'b0;
    wait_op(4, gp, gq, at);
    check("t4_pop_second", gq, 1);
    check("t4_pop_spacing", at - prev, 2);
    tick();
    pop_valid = 1'b0;
    repeat (3) tick();
    check("t4_nrsp", got_q.size(), 1);
    if (got_q.size() == 1) check("t4_rsp", got_q[0], 16'h0005);
    check("t4_count", count, 0);

    // 5: fill to capacity, push blocked, one pop frees a slot
    do_reset();
    for (int i = 0; i < int'(CAP); i++) push_one(0, 16'h0100 + 16'(i), "t5_fill");
    check("t5_full", full, 1);
    check("t5_count", count, CAP);
    push_data[DW +: DW] = 16'h0007;
    push_valid[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5_blocked_ready", push_ready, 0);
      check("t5_blocked_push", tree_push, 0);
    end
    tick();
    pop_valid = 1'b1;
    wait_op(4, gp, gq, at);
    check("t5_pop", gq, 1);
    check("t5_pop_no_push", gp, 0);
    tick();
    pop_valid = 1'b0;
    wait_op(4, gp, gq, at);
    check("t5_resume_push", gp, 1);
    check("t5_resume_ready", push_ready, 4'b0010);
    check("t5_resume_data", tree_push_data, 16'h0007);
    tick();
    push_valid[1] = 1'b0;
    tick();
    check("t5_refull", full, 1);

    // 6: alternating push/pop, then reset with a pop in flight
    do_reset();
    push_one(0, 16'h0040, "t6a");
    push_one(1, 16'h0041, "t6b");
    push_data[2*DW +: DW] = 16'h0050;
    push_valid[2] = 1'b1;
    pop_valid = 1'b1;
    prev = 0;
    for (int n = 0; n < 3; n++) begin
      wait_op(4, gp, gq, at);
      check("t6_is_pop", gq, (n % 2 == 0) ? 1 : 0);
      check("t6_is_push", gp, (n % 2 == 1) ? 1 : 0);
      if (n > 0) check("t6_spacing", at - prev, 2);
      prev = at;
    end
    tick();
    rst_n = 1'b0;
    push_valid = '0;
    pop_valid = 1'b0;
    @(negedge clk);
    check("t6_rst_rsp", rsp_valid, 0);
    check("t6_rst_count", count, 0);
    tick();
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t6_no_rsp", rsp_valid, 0);
      check("t6_count", count, 0);
    end

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
